// File: rtl/dup_inst_mq_fifo.sv
// dup_inst_mq_fifo: multi-lane write / multi-lane pop instruction FIFO with back-pressure, flush and sticky error
module dup_inst_mq_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter int PTR_W     = 5,
    parameter int WR_LANES  = 8,
    parameter int RD_LANES  = 2,
    parameter int NUM_W     = 4,
    parameter int AF_THRESH = 24
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    input  logic                         i_wr_valid,
    input  logic [NUM_W-1:0]             i_wr_num,
    input  logic [WR_LANES*DATA_W-1:0]   i_wr_data,
    output logic                         o_wr_ready,
    input  logic [NUM_W-1:0]             i_rd_num,
    output logic [NUM_W-1:0]             o_rd_avail,
    output logic [RD_LANES*DATA_W-1:0]   o_rd_data,
    output logic [PTR_W:0]               o_count,
    output logic                         o_empty,
    output logic                         o_almost_full,
    output logic                         o_proto_err
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;
    logic              r_proto_err;
    logic              w_wr_ready;
    logic              w_wr_fire;
    logic              w_wr_err;
    logic              w_rd_err;
    logic [NUM_W-1:0]  w_rd_avail;
    logic [NUM_W-1:0]  w_wn;
    logic [NUM_W-1:0]  w_pn;

    assign w_wr_ready = ((PTR_W+1)'(DEPTH) - r_count) >= (PTR_W+1)'(WR_LANES);
    assign w_wr_fire  = i_wr_valid && w_wr_ready && (i_wr_num != '0) && (i_wr_num <= NUM_W'(WR_LANES));
    assign w_wr_err   = i_wr_valid && !w_wr_fire;
    assign w_rd_avail = (r_count < (PTR_W+1)'(RD_LANES)) ? NUM_W'(r_count) : NUM_W'(RD_LANES);
    assign w_rd_err   = i_rd_num > w_rd_avail;
    assign w_pn       = w_rd_err ? w_rd_avail : i_rd_num;
    assign w_wn       = w_wr_fire ? i_wr_num : '0;

    assign o_wr_ready    = w_wr_ready;
    assign o_rd_avail    = w_rd_avail;
    assign o_count       = r_count;
    assign o_empty       = r_count == '0;
    assign o_almost_full = r_count > (PTR_W+1)'(AF_THRESH);
    assign o_proto_err   = r_proto_err;

    // Read lanes look ahead from rptr; lanes beyond the available count read as zero
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < RD_LANES; i++)
            if (NUM_W'(i) < w_rd_avail) o_rd_data[i*DATA_W +: DATA_W] = r_mem[r_rptr + PTR_W'(i)];
    end

    // Accepted lanes land at consecutive addresses that wrap independently; a flush discards the write
    always_ff @(posedge i_clk) begin
        if (w_wr_fire && !i_flush)
            for (int i = 0; i < WR_LANES; i++)
                if (NUM_W'(i) < i_wr_num) r_mem[r_wptr + PTR_W'(i)] <= i_wr_data[i*DATA_W +: DATA_W];
    end

    // Pointers, occupancy and the sticky error; flush wins over write and pop and holds the error flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_proto_err <= 1'b0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(w_wn);
            r_rptr  <= r_rptr + PTR_W'(w_pn);
            r_count <= r_count + (PTR_W+1)'(w_wn) - (PTR_W+1)'(w_pn);
            if (w_wr_err || w_rd_err) r_proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dup_inst_mq_fifo.sv
// tb_dup_inst_mq_fifo: scenario tasks with a queue scoreboard for the multi-lane instruction FIFO
module tb_dup_inst_mq_fifo;
    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          wr_valid;
    logic [3:0]    wr_num;
    logic [255:0]  wr_data;
    logic          wr_ready;
    logic [3:0]    rd_num;
    logic [3:0]    rd_avail;
    logic [63:0]   rd_data;
    logic [5:0]    count;
    logic          empty;
    logic          almost_full;
    logic          proto_err;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] q[$];
    int          next_val = 0;

    always #5 clk = ~clk;

    dup_inst_mq_fifo dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_wr_valid(wr_valid),
        .i_wr_num(wr_num), .i_wr_data(wr_data), .o_wr_ready(wr_ready), .i_rd_num(rd_num),
        .o_rd_avail(rd_avail), .o_rd_data(rd_data), .o_count(count), .o_empty(empty),
        .o_almost_full(almost_full), .o_proto_err(proto_err)
    );

    // One clock of stimulus; rd lanes are checked against the scoreboard head before the edge
    task automatic cycle(input bit v, input int wn, input int rn, input bit fl);
        int avail;
        int pn;
        bit ok;
        logic [31:0] e;
        wr_valid = v;
        wr_num = 4'(wn);
        rd_num = 4'(rn);
        flush = fl;
        for (int i = 0; i < 8; i++) wr_data[i*32 +: 32] = (i < wn) ? 32'(next_val + i) : (32'hBAD0_0000 | 32'(i));
        #1;
        avail = q.size() < 2 ? q.size() : 2;
        checks++;
        if (rd_avail !== 4'(avail)) begin failures++; $display("FAIL rd_avail got=%0d exp=%0d", rd_avail, avail); end
        for (int i = 0; i < 2; i++) begin
            e = (i < avail) ? q[i] : 32'h0;
            checks++;
            if (rd_data[i*32 +: 32] !== e) begin failures++; $display("FAIL rd_data lane%0d got=%h exp=%h", i, rd_data[i*32 +: 32], e); end
        end
        ok = v && wn >= 1 && wn <= 8 && (32 - q.size()) >= 8;
        pn = rn < avail ? rn : avail;
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else begin
            repeat (pn) void'(q.pop_front());
            if (ok) for (int i = 0; i < wn; i++) q.push_back(32'(next_val + i));
        end
        next_val += 8;
        wr_valid = 1'b0;
        wr_num = '0;
        rd_num = '0;
        flush = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        checks++;
        if (count !== 6'd0 || empty !== 1'b1 || wr_ready !== 1'b1 || almost_full !== 1'b0 || proto_err !== 1'b0 || rd_avail !== 4'd0 || rd_data !== 64'h0) begin
            failures++; $display("FAIL reset_state count=%0d empty=%b rdy=%b af=%b err=%b avail=%0d data=%h", count, empty, wr_ready, almost_full, proto_err, rd_avail, rd_data);
        end
        cycle(1, 8, 0, 0);
        checks++;
        if (count !== 6'd8) begin failures++; $display("FAIL pre_reset_count got=%0d exp=8", count); end
        wr_valid = 1'b1;
        wr_num = 4'd8;
        rd_num = 4'd2;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 6'd0 || empty !== 1'b1 || wr_ready !== 1'b1 || rd_data !== 64'h0) begin
            failures++; $display("FAIL async_reset count=%0d empty=%b rdy=%b data=%h exp 0/1/1/0", count, empty, wr_ready, rd_data);
        end
        wr_valid = 1'b0;
        wr_num = '0;
        rd_num = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_burst();
        for (int k = 0; k < 3; k++) cycle(1, 8, 0, 0);
        checks++;
        if (count !== 6'd24 || almost_full !== 1'b0 || wr_ready !== 1'b1) begin
            failures++; $display("FAIL burst24 count=%0d af=%b rdy=%b exp 24/0/1", count, almost_full, wr_ready);
        end
        cycle(1, 1, 0, 0);
        checks++;
        if (count !== 6'd25 || almost_full !== 1'b1 || wr_ready !== 1'b0 || proto_err !== 1'b0) begin
            failures++; $display("FAIL burst25 count=%0d af=%b rdy=%b err=%b exp 25/1/0/0", count, almost_full, wr_ready, proto_err);
        end
    endtask

    task automatic test_back_pressure();
        cycle(1, 1, 0, 0);
        checks++;
        if (count !== 6'd25 || proto_err !== 1'b1) begin
            failures++; $display("FAIL back_pressure count=%0d err=%b exp 25/1", count, proto_err);
        end
        for (int k = 0; k < 13; k++) cycle(0, 0, 2, 0);
        checks++;
        if (count !== 6'd0 || empty !== 1'b1 || proto_err !== 1'b1) begin
            failures++; $display("FAIL drain_sticky count=%0d empty=%b err=%b exp 0/1/1", count, empty, proto_err);
        end
    endtask

    task automatic test_illegal_num();
        apply_reset();
        cycle(1, 0, 0, 0);
        checks++;
        if (count !== 6'd0 || proto_err !== 1'b1) begin failures++; $display("FAIL wr_num0 count=%0d err=%b exp 0/1", count, proto_err); end
        apply_reset();
        cycle(1, 9, 0, 0);
        checks++;
        if (count !== 6'd0 || proto_err !== 1'b1) begin failures++; $display("FAIL wr_num9 count=%0d err=%b exp 0/1", count, proto_err); end
    endtask

    task automatic test_wrap();
        apply_reset();
        cycle(1, 8, 0, 0);
        cycle(1, 8, 0, 0);
        cycle(1, 8, 0, 0);
        cycle(1, 4, 0, 0);
        for (int k = 0; k < 14; k++) cycle(0, 0, 2, 0);
        checks++;
        if (count !== 6'd0 || proto_err !== 1'b0) begin failures++; $display("FAIL wrap_preload count=%0d err=%b exp 0/0", count, proto_err); end
        cycle(1, 8, 0, 0);
        checks++;
        if (count !== 6'd8) begin failures++; $display("FAIL wrap_write count=%0d exp 8", count); end
        for (int k = 0; k < 4; k++) cycle(0, 0, 2, 0);
        checks++;
        if (count !== 6'd0 || empty !== 1'b1 || q.size() != 0) begin failures++; $display("FAIL wrap_drain count=%0d empty=%b exp 0/1", count, empty); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        cycle(1, 1, 0, 0);
        cycle(1, 5, 2, 0);
        checks++;
        if (count !== 6'd5 || proto_err !== 1'b1) begin failures++; $display("FAIL simultaneous count=%0d err=%b exp 5/1", count, proto_err); end
        cycle(1, 3, 2, 0);
        checks++;
        if (count !== 6'd6) begin failures++; $display("FAIL simultaneous2 count=%0d exp 6", count); end
        for (int k = 0; k < 3; k++) cycle(0, 0, 2, 0);
    endtask

    task automatic test_flush();
        apply_reset();
        cycle(1, 8, 0, 0);
        cycle(1, 2, 0, 0);
        checks++;
        if (count !== 6'd10) begin failures++; $display("FAIL flush_pre count=%0d exp 10", count); end
        cycle(1, 4, 2, 1);
        checks++;
        if (count !== 6'd0 || empty !== 1'b1 || proto_err !== 1'b0) begin
            failures++; $display("FAIL flush count=%0d empty=%b err=%b exp 0/1/0", count, empty, proto_err);
        end
        cycle(1, 3, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 2, 0);
        checks++;
        if (count !== 6'd0 || empty !== 1'b1) begin failures++; $display("FAIL flush_after count=%0d empty=%b exp 0/1", count, empty); end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        wr_valid = 1'b0;
        wr_num = '0;
        wr_data = '0;
        rd_num = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_burst();
        test_back_pressure();
        test_illegal_num();
        test_wrap();
        test_simultaneous();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
